// File: rtl/reset_sequencer.sv
// Board reset and PLL bring-up: holds the PLL in reset, waits for a stable
// lock, then releases downstream reset domains in order, gap-spaced.
module reset_sequencer #(
    parameter int NUM_STAGES       = 3,
    parameter int PLL_RST_CYC      = 12,
    parameter int LOCK_TIMEOUT_CYC = 12000,
    parameter int LOCK_STABLE_CYC  = 1200,
    parameter int STAGE_GAP_CYC    = 16,
    parameter int MAX_RETRIES      = 3
) (
    input  logic                               OSCCLK,
    input  logic                               EXTRST,
    input  logic                               PLL_LOCKED,
    output logic                               PLL_RST,
    output logic [NUM_STAGES-1:0]              STAGE_RST,
    output logic                               READY,
    output logic                               FAULT,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   RETRY_CNT
);

    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int M1 = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
    localparam int M2 = (M1 > LOCK_STABLE_CYC) ? M1 : LOCK_STABLE_CYC;
    localparam int M3 = (M2 > STAGE_GAP_CYC) ? M2 : STAGE_GAP_CYC;
    localparam int CW = $clog2(M3 + 1);
    localparam int IW = $clog2(NUM_STAGES + 1);

    localparam logic [CW-1:0] C_PLL  = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] C_TO   = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] C_STB  = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0] C_GAP  = CW'(STAGE_GAP_CYC - 1);
    localparam logic [IW-1:0] I_DONE = IW'(NUM_STAGES);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [1:0]      sync_q;
    logic            lock_s;
    logic            restart;
    logic            give_up;

    assign lock_s = sync_q[1];

    always_ff @(posedge OSCCLK or posedge EXTRST) begin
        if (EXTRST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], PLL_LOCKED};
        end
    end

    // Lock timeout and lock loss after release share one recovery path
    always_comb begin
        restart = 1'b0;
        if (!lock_s) begin
            if (state == S_WAIT_LOCK && cnt == C_TO) begin
                restart = 1'b1;
            end
            if (state == S_RELEASE || state == S_RUN) begin
                restart = 1'b1;
            end
        end
    end

    assign give_up = (RETRY_CNT == R_MAX);

    always_ff @(posedge OSCCLK or posedge EXTRST) begin
        if (EXTRST) begin
            state     <= S_PLL_RESET;
            cnt       <= '0;
            idx       <= '0;
            PLL_RST   <= 1'b1;
            STAGE_RST <= '1;
            READY     <= 1'b0;
            FAULT     <= 1'b0;
            RETRY_CNT <= '0;
        end else if (restart) begin
            STAGE_RST <= '1;
            READY     <= 1'b0;
            PLL_RST   <= 1'b1;
            cnt       <= '0;
            idx       <= '0;
            if (give_up) begin
                state <= S_FAULT;
                FAULT <= 1'b1;
            end else begin
                state     <= S_PLL_RESET;
                RETRY_CNT <= RETRY_CNT + 1'b1;
            end
        end else begin
            unique case (state)
                S_PLL_RESET: begin
                    if (cnt == C_PLL) begin
                        state   <= S_WAIT_LOCK;
                        PLL_RST <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == C_STB) begin
                        state <= S_RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    // idx == I_DONE means the last stage went out last edge
                    if (idx == I_DONE) begin
                        state     <= S_RUN;
                        READY     <= 1'b1;
                        RETRY_CNT <= '0;
                    end else if (cnt == C_GAP) begin
                        STAGE_RST[idx] <= 1'b0;
                        idx            <= idx + 1'b1;
                        cnt            <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    READY <= 1'b1;
                end
                S_FAULT: begin
                    PLL_RST   <= 1'b1;
                    STAGE_RST <= '1;
                    FAULT     <= 1'b1;
                end
                default: begin
                    state <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Board-level reset and clock-bring-up controller for the rover FPGA. It sits directly behind the 12 MHz oscillator input and external reset. It holds the clock-converter PLL in reset and waits for a stable lock, then releases the downstream subsystem reset domains one stage at a time, gap-spaced. It re-sequences automatically on lock loss and raises a sticky fault after repeated lock failures.

## Interface
- NUM_STAGES, 3: number of downstream reset domains; released in index order, 0 first.
- PLL_RST_CYC, 12: PLL reset pulse width in OSCCLK cycles (1 µs).
- LOCK_TIMEOUT_CYC, 12000: cycles allowed for lock after each PLL reset (1 ms).
- LOCK_STABLE_CYC, 1200: consecutive synchronized-lock cycles required before release (100 µs).
- STAGE_GAP_CYC, 16: cycles between successive stage releases.
- MAX_RETRIES, 3: PLL reset retries allowed before FAULT.

- OSCCLK  in  1  12 MHz oscillator; the only clock.
- EXTRST  in  1  external reset, asynchronous, active-high.
- PLL_LOCKED  in  1  PLL lock indicator, asynchronous to OSCCLK.
- PLL_RST  out  1  PLL reset, active-high.
- STAGE_RST  out  NUM_STAGES  per-domain reset, active-high.
- READY  out  1  all stages released, system running.
- FAULT  out  1  sticky lock-failure flag.
- RETRY_CNT  out  $clog2(MAX_RETRIES+1)  retries consumed in the current bring-up.

## Operation
- All outputs are registered. While EXTRST=1: PLL_RST=1, STAGE_RST all ones, READY=0, FAULT=0, RETRY_CNT=0, state=PLL_RESET, all counters 0.
- PLL_LOCKED passes through a 2-flop synchronizer, giving lock_s. The synchronizer is cleared by EXTRST.
- States: PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT.
- PLL_RESET: PLL_RST=1 for PLL_RST_CYC cycles, then go to WAIT_LOCK with PLL_RST=0 and the counter cleared.
- WAIT_LOCK: count cycles.
  - lock_s=1: go to STABLE with the counter cleared.
  - Counter reaches LOCK_TIMEOUT_CYC-1 without lock, RETRY_CNT<MAX_RETRIES: RETRY_CNT++ and go to PLL_RESET.
  - Same timeout with RETRY_CNT=MAX_RETRIES: go to FAULT.
- STABLE: count consecutive lock_s=1 cycles.
  - lock_s=0: return to WAIT_LOCK with the timeout counter restarted. No retry is consumed.
  - Count reaches LOCK_STABLE_CYC: go to RELEASE with stage index 0.
- RELEASE: STAGE_RST[k] deasserts (k+1)·STAGE_GAP_CYC cycles after RELEASE entry. After stage NUM_STAGES-1 deasserts, go to RUN on the next edge.
- RUN: READY=1. RETRY_CNT clears to 0 on RUN entry.
- Lock loss (lock_s=0) in RELEASE or RUN, next edge:
  - STAGE_RST returns to all ones and READY=0.
  - RETRY_CNT++ and go to PLL_RESET, or go to FAULT if RETRY_CNT=MAX_RETRIES.
- FAULT: PLL_RST=1, STAGE_RST all ones, READY=0, FAULT=1. Exit only via EXTRST.
- STAGE_RST bits never deassert out of index order. Once a bit is asserted it stays asserted until the RELEASE schedule reaches it.
- EXTRST asserted mid-operation, from any state: immediate asynchronous return to the reset values listed above.

## Timing
- Edge n is the nth rising OSCCLK edge after EXTRST falls (first edge is n=1).
- PLL_RST falls at edge PLL_RST_CYC.
- PLL_LOCKED to lock_s latency is 2 edges. Lock loss reaches STAGE_RST/READY 3 edges after the PLL_LOCKED fall (2 sync + 1 register).
- Lock-to-READY latency: 2 + 1 + LOCK_STABLE_CYC + NUM_STAGES·STAGE_GAP_CYC + 1 edges after PLL_LOCKED rises (PLL_LOCKED held high).
- A retry adds exactly PLL_RST_CYC + LOCK_TIMEOUT_CYC edges.
- When lock loss and a stage release fall on the same edge, lock loss wins: the stage remains asserted.

## Test plan
Bench parameters: NUM_STAGES=3, PLL_RST_CYC=4, LOCK_TIMEOUT_CYC=32, LOCK_STABLE_CYC=8, STAGE_GAP_CYC=4, MAX_RETRIES=2.

1. Clean bring-up:
   - Stimulus: EXTRST falls, PLL_LOCKED rises at edge 10 and stays high.
   - Response: PLL_RST falls at edge 4; STAGE_RST goes 111→110→100→000, four edges apart; READY=1 one edge after STAGE_RST=000; FAULT=0.
2. Glitchy lock:
   - Stimulus: PLL_LOCKED high 5 cycles, low 1 cycle, then high.
   - Response: STABLE restarts, RETRY_CNT stays 0, PLL_RST stays 0, and release begins only after 8 consecutive lock_s cycles.
3. Timeout retries to fault:
   - Stimulus: PLL_LOCKED tied 0.
   - Response: three PLL_RST pulses of 4 cycles each, 36 edges apart; RETRY_CNT steps 0→1→2; FAULT=1 after the third timeout, sticky until EXTRST.
4. Lock loss in RUN:
   - Stimulus: drop PLL_LOCKED while READY=1.
   - Response: STAGE_RST=111 and READY=0 three edges later, PLL_RST=1, RETRY_CNT=1. After lock returns, the full sequence repeats and RETRY_CNT returns to 0 at READY.
5. Lock loss during RELEASE:
   - Stimulus: drop PLL_LOCKED after STAGE_RST=110.
   - Response: STAGE_RST returns to 111; stages 1 and 2 never deassert; the sequence restarts from PLL_RESET.
6. Asynchronous reset mid-RELEASE:
   - Stimulus: pulse EXTRST between clock edges.
   - Response: PLL_RST=1, STAGE_RST=111, READY=0, FAULT=0 before the next edge; a clean restart follows.
